pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/hazard_detect.sv | 12 +
 rtl/pipe_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types and the pipeline-control state encoding.
package cpu_types_pkg;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {RUN, MWAIT, HALTED} pctrl_state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the EX load and the ID source registers.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_memread,
  input  regbits_t ex_rd,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     lu_hazard
);
  assign lu_hazard = ex_memread && (ex_rd != '0) && (ex_rd == id_rs || ex_rd == id_rt);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/halt control; PIPE_CTRL_PERF_EN adds
// saturating stall-cycle and flush-event counters.
module pipe_ctrl
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     mem_req,
  input  logic     ex_memread,
  input  regbits_t ex_rd,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     br_taken,
  input  logic     wb_halt,
  output logic     pc_en,
  output logic     ifid_stall,
  output logic     ifid_flush,
  output logic     idex_stall,
  output logic     idex_flush,
  output logic     exmem_stall,
  output logic     exmem_flush,
  output logic     memwb_stall,
`ifdef PIPE_CTRL_PERF_EN
  output word_t    stall_cycles,
  output word_t    flush_events,
`endif
  output logic     halt
);
  pctrl_state_t state_q, state_d, st;
  logic lu_hazard, mwait;
  hazard_detect u_hd (
    .ex_memread(ex_memread),
    .ex_rd     (ex_rd),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .lu_hazard (lu_hazard)
  );
  // outputs decode as RUN while reset is held
  assign st = RST ? RUN : state_q;
  assign mwait = !dhit && ((st == MWAIT) || (st == RUN && mem_req));
  always_comb begin
    state_d = (state_q == HALTED || wb_halt) ? HALTED :
              (state_q == RUN && mem_req && !dhit) ? MWAIT :
              (state_q == MWAIT && dhit) ? RUN : state_q;
  end
  always_comb begin
    pc_en       = ihit;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    memwb_stall = 1'b0;
    halt        = 1'b0;
    if (st == HALTED || mwait) begin
      halt        = (st == HALTED);
      pc_en       = 1'b0;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
    end else if (br_taken) begin
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end
`ifdef PIPE_CTRL_PERF_EN
  word_t stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = (!pc_en && state_q != HALTED && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    flush_d = (ifid_flush && flush_q != '1) ? flush_q + 32'd1 : flush_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, RST;
  logic ihit, dhit, mem_req, ex_memread, br_taken, wb_halt;
  regbits_t ex_rd, id_rs, id_rt;
  logic pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, exmem_flush, memwb_stall, halt;
  int n_chk = 0, n_err = 0;
`ifdef PIPE_CTRL_PERF_EN
  word_t stall_cycles, flush_events;
`endif
  // {pc_en, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, halt}
  localparam logic [8:0] DEF = 9'b100000000, STL = 9'b010101010, HLT = 9'b010101011;
  localparam logic [8:0] BR  = 9'b101010000, LU  = 9'b010010000, IMS = 9'b001000000;
  pipe_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .br_taken(br_taken), .wb_halt(wb_halt), .pc_en(pc_en),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_flush(idex_flush), .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .memwb_stall(memwb_stall),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .halt(halt)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    RST = 0; ihit = 1; dhit = 0; mem_req = 0; ex_memread = 0;
    ex_rd = 0; id_rs = 0; id_rt = 0; br_taken = 0; wb_halt = 0;
  endtask
  task automatic outs(input string tag, input logic [8:0] exp);
    #1;
    check(tag, {23'd0, pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, exmem_flush, memwb_stall, halt}, {23'd0, exp});
  endtask
  task automatic tick();
    @(negedge CLK);
  endtask
  initial begin
    idle(); RST = 1;
    tick();
    outs("rst_default", DEF);
    mem_req = 1;
    outs("rst_run_decode", STL);
    tick(); idle();
    outs("default", DEF);
    ihit = 0;
    outs("imiss", IMS);
    tick(); idle();
    mem_req = 1;
    outs("mw_c1", STL);
    tick();
    outs("mw_c2", STL);
    tick(); mem_req = 0;
    outs("mw_c3_held", STL);
    tick(); dhit = 1; mem_req = 1;
    outs("mw_release", DEF);
    tick(); idle();
    outs("mw_back_run", DEF);
    ex_memread = 1; ex_rd = 5; id_rt = 5;
    outs("lu_rt", LU);
    id_rt = 0; id_rs = 5;
    outs("lu_rs", LU);
    ihit = 0;
    outs("lu_over_imiss", LU);
    ihit = 1; ex_rd = 0; id_rs = 0;
    outs("lu_rd0", DEF);
    ex_memread = 0; ex_rd = 5; id_rt = 5;
    outs("lu_no_load", DEF);
    ex_memread = 1; br_taken = 1;
    outs("br_over_lu", BR);
    idle(); br_taken = 1; ihit = 0;
    outs("br_imiss", BR);
    tick(); idle();
    mem_req = 1; br_taken = 1;
    outs("br_mw_c1", STL);
    tick(); mem_req = 0;
    outs("br_mw_c2", STL);
    tick(); dhit = 1;
    outs("br_mw_release", BR);
    tick(); idle();
    mem_req = 1;
    tick(); mem_req = 0; RST = 1;
    outs("rst_mid_mwait", DEF);
    tick(); idle();
    outs("after_mw_rst", DEF);
    wb_halt = 1;
    outs("halt_cycle", DEF);
    tick(); idle();
    outs("halted", HLT);
    ihit = 0;
    outs("halted_imiss", HLT);
    tick(); ihit = 1; br_taken = 1;
    outs("halted_br", HLT);
    mem_req = 1; dhit = 1;
    outs("halted_mem", HLT);
    tick(); idle(); RST = 1;
    outs("rst_in_halt", DEF);
    tick(); idle();
    outs("after_halt_rst", DEF);
`ifdef PIPE_CTRL_PERF_EN
    RST = 1;
    tick(); idle();
    check("cnt_clr_stall", stall_cycles, 32'd0);
    check("cnt_clr_flush", flush_events, 32'd0);
    ex_memread = 1; ex_rd = 7; id_rs = 7;
    repeat (4) tick();
    idle(); br_taken = 1;
    repeat (2) tick();
    idle();
    tick();
    check("cnt_stall", stall_cycles, 32'd4);
    check("cnt_flush", flush_events, 32'd2);
    dut.stall_q = 32'hFFFF_FFFE;
    ex_memread = 1; ex_rd = 7; id_rs = 7;
    repeat (3) tick();
    idle();
    #1 check("cnt_sat", stall_cycles, 32'hFFFF_FFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
